// File: rtl/serial_uart_buffer.sv
// Byte buffer between host bus and UART core: a TX FIFO draining into the UART
// strobe/busy handshake, and an RX FIFO capturing UART bytes with sticky overrun.
module serial_uart_buffer #(
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            host_wr_data,
    input  logic                  host_wr_en,
    output logic                  host_tx_full,
    output logic [DEPTH_BITS:0]   host_tx_count,
    output logic [7:0]            host_rd_data,
    input  logic                  host_rd_en,
    output logic                  host_rx_empty,
    output logic [DEPTH_BITS:0]   host_rx_count,
    output logic                  host_rx_overrun,
    input  logic                  host_overrun_clr,
    output logic [7:0]            as_data_o,
    output logic                  as_dstrb_o,
    input  logic                  as_busy_i,
    input  logic [7:0]            as_data_i,
    input  logic                  as_dstrb_i
);
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   CNT_FULL = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   CNT_ONE  = (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

    logic [DATA_W-1:0]     tx_mem [DEPTH];
    logic [DATA_W-1:0]     rx_mem [DEPTH];
    logic [DEPTH_BITS-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [DEPTH_BITS:0]   tx_count, rx_count;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_push, tx_pop, rx_push, rx_pop, rx_drop;
    logic                  overrun;

    assign tx_full  = (tx_count == CNT_FULL);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CNT_FULL);
    assign rx_empty = (rx_count == '0);

    // Holding off while our own strobe is out keeps strobes at least one cycle apart
    // even before the UART's busy reaches us.
    assign tx_pop  = !tx_empty && !as_busy_i && !as_dstrb_o;
    assign tx_push = host_wr_en && (!tx_full || tx_pop);
    assign rx_pop  = host_rd_en && !rx_empty;
    assign rx_push = as_dstrb_i && (!rx_full || rx_pop);
    assign rx_drop = as_dstrb_i && rx_full && !rx_pop;

    // TX side: pointers, occupancy and the registered UART strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr    <= '0;
            tx_rptr    <= '0;
            tx_count   <= '0;
            as_dstrb_o <= 1'b0;
            as_data_o  <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop) begin
                tx_rptr   <= tx_rptr + PTR_ONE;
                as_data_o <= tx_mem[tx_rptr];
            end
            as_dstrb_o <= tx_pop;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_ONE;
                2'b01:   tx_count <= tx_count - CNT_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // RX side: pointers, occupancy and sticky overrun (a new drop beats a clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            overrun  <= 1'b0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_ONE;
                2'b01:   rx_count <= rx_count - CNT_ONE;
                default: rx_count <= rx_count;
            endcase
            if (rx_drop)               overrun <= 1'b1;
            else if (host_overrun_clr) overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && tx_push) tx_mem[tx_wptr] <= host_wr_data;
        if (!reset && rx_push) rx_mem[rx_wptr] <= as_data_i;
    end

    assign host_tx_full    = tx_full;
    assign host_tx_count   = tx_count;
    assign host_rx_empty   = rx_empty;
    assign host_rx_count   = rx_count;
    assign host_rx_overrun = overrun;
    assign host_rd_data    = rx_mem[rx_rptr];
endmodule
